// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Brief    : Instruction-fetch stage. Owns the PC, drives the IM fetch
//             address, loads the IF/ID register and applies stall, redirect
//             and halt control.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_INST = 32'h0000_0073,
   parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_IF,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] current_pc,
   output logic [3:0]  F_im_w_en,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count,
   output logic        misalign_err
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state_q,       state_d;
   logic [31:0] pc_q,          pc_d;
   logic [31:0] if_id_pc_q,    if_id_pc_d;
   logic [31:0] if_id_inst_q,  if_id_inst_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        misalign_q,    misalign_d;

   // Next-state: redirect beats stall beats normal fetch; everything holds by default
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
      if_id_valid_d = if_id_valid_q;
      fetch_count_d = fetch_count_q;
      misalign_d    = misalign_q;

      if (redirect) begin
         // Target is word-aligned by dropping the low bits; the wrong-path
         // instruction currently in IF/ID is squashed into a bubble.
         pc_d          = {redirect_pc[31:2], 2'b00};
         if_id_pc_d    = 32'h0000_0000;
         if_id_inst_d  = NOP_INST;
         if_id_valid_d = 1'b0;
         state_d       = ST_RUN;
         misalign_d    = misalign_q | (redirect_pc[1:0] != 2'b00);
      end else if (!stall) begin
         case (state_q)
            ST_RUN: begin
               if_id_pc_d    = pc_q;
               if_id_inst_d  = inst_IF;
               if_id_valid_d = 1'b1;
               fetch_count_d = fetch_count_q + 32'd1;
               if (inst_IF == HALT_INST) begin
                  // Halt instruction goes downstream once; PC parks on it
                  state_d = ST_HALT;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
            ST_HALT: begin
               if_id_pc_d    = 32'h0000_0000;
               if_id_inst_d  = NOP_INST;
               if_id_valid_d = 1'b0;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 32'h0000_0000;
         if_id_inst_q  <= NOP_INST;
         if_id_valid_q <= 1'b0;
         fetch_count_q <= 32'h0000_0000;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         if_id_valid_q <= if_id_valid_d;
         fetch_count_q <= fetch_count_d;
         misalign_q    <= misalign_d;
      end
   end

   assign current_pc   = pc_q;
   assign F_im_w_en    = 4'b0000;
   assign if_id_pc     = if_id_pc_q;
   assign if_id_inst   = if_id_inst_q;
   assign if_id_valid  = if_id_valid_q;
   assign halted       = (state_q == ST_HALT);
   assign fetch_count  = fetch_count_q;
   assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Brief    : Scoreboard bench for if_fetch_stage. A driver issues directed
//             and random control, a reference model predicts the outputs
//             after each edge, and a monitor compares them one cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

   localparam logic [31:0] C_HALT_INST = 32'h0000_0073;
   localparam logic [31:0] C_NOP_INST  = 32'h0000_0013;
   localparam logic [31:0] C_HALT_ADDR = 32'h0000_001C;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ifpc;
      logic [31:0] ifinst;
      logic        ifvalid;
      logic        halted;
      logic [31:0] count;
      logic        err;
   } snap_t;

   logic        clk;
   logic        rst;
   logic [31:0] inst_IF;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] current_pc;
   logic [3:0]  F_im_w_en;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic        halted;
   logic [31:0] fetch_count;
   logic        misalign_err;

   int    tests_run = 0;
   int    tests_failed = 0;
   bit    started = 1'b0;
   snap_t sb[$];
   snap_t m;

   // Program image: halt at one fixed address, distinct non-halt words elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == C_HALT_ADDR) return C_HALT_INST;
      return {a[26:2] ^ 25'h155_5555, 7'h33};
   endfunction

   assign inst_IF = mem_word(current_pc);

   if_fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .inst_IF     (inst_IF),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .current_pc  (current_pc),
      .F_im_w_en   (F_im_w_en),
      .if_id_pc    (if_id_pc),
      .if_id_inst  (if_id_inst),
      .if_id_valid (if_id_valid),
      .halted      (halted),
      .fetch_count (fetch_count),
      .misalign_err(misalign_err)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour of one rising edge, written from the fetch rules
   task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      logic [31:0] inst;
      if (!r) begin
         m = '{pc: 32'h0, ifpc: 32'h0, ifinst: C_NOP_INST, ifvalid: 1'b0,
               halted: 1'b0, count: 32'h0, err: 1'b0};
      end else if (rd) begin
         m.pc      = rpc & 32'hFFFF_FFFC;
         m.ifpc    = 32'h0;
         m.ifinst  = C_NOP_INST;
         m.ifvalid = 1'b0;
         m.halted  = 1'b0;
         if (rpc % 4 != 0) m.err = 1'b1;
      end else if (s) begin
         // everything holds
      end else if (m.halted) begin
         m.ifpc    = 32'h0;
         m.ifinst  = C_NOP_INST;
         m.ifvalid = 1'b0;
      end else begin
         inst      = mem_word(m.pc);
         m.ifpc    = m.pc;
         m.ifinst  = inst;
         m.ifvalid = 1'b1;
         m.count   = m.count + 1;
         if (inst == C_HALT_INST) m.halted = 1'b1;
         else                     m.pc = m.pc + 4;
      end
   endtask

   // Drive one cycle of control and queue the predicted post-edge outputs
   task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      rst         = r;
      stall       = s;
      redirect    = rd;
      redirect_pc = rpc;
      model_edge(r, s, rd, rpc);
      sb.push_back(m);
      started = 1'b1;
   endtask

   // Monitor: every output is registered, so one snapshot is due per edge
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("current_pc",   current_pc,   e.pc);
            check("if_id_pc",     if_id_pc,     e.ifpc);
            check("if_id_inst",   if_id_inst,   e.ifinst);
            check("if_id_valid",  {31'b0, if_id_valid},  {31'b0, e.ifvalid});
            check("halted",       {31'b0, halted},       {31'b0, e.halted});
            check("fetch_count",  fetch_count,  e.count);
            check("misalign_err", {31'b0, misalign_err}, {31'b0, e.err});
            check("F_im_w_en",    {28'b0, F_im_w_en},    32'h0);
         end else if (started) begin
            check("scoreboard_empty", 32'd1, 32'd0);
         end
      end
   end

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 32'h44);                           // reset beats redirect/stall
      // Straight-line fetch 0,4 then stall twice at PC=8, then resume
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);               // now at 0x10
      cyc(1, 1, 1, 32'h40);                           // redirect wins over stall
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h42);                           // misaligned -> 0x40, sticky err
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h10);                           // aligned redirect, err stays
      // Run into the halt at 0x1C, bubbles, stall in HALT, then leave via redirect
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
      cyc(1, 0, 1, 32'h0);
      cyc(1, 0, 0, 0);
      // Redirect in the same cycle the halt word is fetched
      cyc(1, 0, 1, 32'h18); cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h100);
      cyc(1, 0, 0, 0);
      // Halt with several fetches counted, then reset while halted
      cyc(1, 0, 1, 32'h8);
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      // PC wrap from FFFF_FFFC to 0
      cyc(1, 0, 1, 32'hFFFF_FFFC);
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      // Randomised control
      for (int i = 0; i < 2000; i++) begin
         logic        r, s, rd;
         logic [31:0] t;
         r  = ($urandom_range(0, 63) != 0);
         s  = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         else                           t = $urandom_range(0, 32'h7F);
         cyc(r, s, rd, t);
      end
      @(negedge clk);
      if (sb.size() != 0) check("scoreboard_drain", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
